// File: rtl/bcrypt_cmp_cfg_pkg.sv
// Shared types and constants for the bcrypt comparator-config parser.
// Holds the parser states, error codes, magic byte and subtype characters.
package bcrypt_cmp_cfg_pkg;

    typedef enum logic [3:0] {
        ST_SALT,
        ST_SUBTYPE,
        ST_ITER,
        ST_HCNT0,
        ST_HCNT1,
        ST_CMP_DATA,
        ST_WAIT,
        ST_MAGIC,
        ST_ERROR
    } cfg_state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_SUBTYPE    = 3'd1;
    localparam logic [2:0] ERR_ITER       = 3'd2;
    localparam logic [2:0] ERR_HCNT_RANGE = 3'd3;
    localparam logic [2:0] ERR_MAGIC      = 3'd4;
    localparam logic [2:0] ERR_HCNT_ZERO  = 3'd5;
    localparam logic [2:0] ERR_HCNT_NOCMP = 3'd6;

    localparam logic [7:0] CFG_MAGIC = 8'hCC;

    localparam logic [7:0] SUB_A = 8'h61;
    localparam logic [7:0] SUB_B = 8'h62;
    localparam logic [7:0] SUB_X = 8'h78;
    localparam logic [7:0] SUB_Y = 8'h79;

    function automatic logic is_valid_subtype(input logic [7:0] c);
        return (c == SUB_A) || (c == SUB_B) || (c == SUB_X) || (c == SUB_Y);
    endfunction

endpackage

// File: rtl/bcrypt_cfg_ctx_ram.sv
// Context store: NUM_CTX banks of 16 x 32-bit words.
// One synchronous write port and one asynchronous read port.
module bcrypt_cfg_ctx_ram #(
    parameter int NUM_CTX = 2,
    parameter int CTX_W   = 1
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [CTX_W-1:0] i_wr_ctx,
    input  logic [3:0]       i_wr_addr,
    input  logic [31:0]      i_wr_data,
    input  logic [CTX_W-1:0] i_rd_ctx,
    input  logic [3:0]       i_rd_addr,
    output logic [31:0]      o_rd_data
);

    logic [31:0] r_mem [NUM_CTX][16];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_wr_ctx][i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_ctx][i_rd_addr];

endmodule

// File: rtl/bcrypt_cmp_config_mc.sv
// Multi-context cmp_config packet parser: fills a shadow context from the byte
// stream and commits it as the active context on the consumer's handshake.
module bcrypt_cmp_config_mc
    import bcrypt_cmp_cfg_pkg::*;
#(
    parameter int NUM_CTX      = 2,
    parameter int SALT_WORDS   = 4,
    parameter int HASH_CNT_W   = 16,
    parameter int HASH_NUM_MAX = 512,
    parameter int CMP_AW       = 11,
    parameter int SETTING_MAX  = 19,
    localparam int CTX_W       = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_din,
    input  logic                  i_wr_en,
    output logic                  o_full,
    output logic                  o_error,
    output logic [2:0]            o_err_code,
    input  logic                  i_err_clr,
    input  logic                  i_mode_cmp,
    output logic                  o_new_cmp_config,
    input  logic                  i_cmp_config_applied,
    output logic [HASH_CNT_W-1:0] o_hash_count,
    output logic [CMP_AW-1:0]     o_cmp_wr_addr,
    output logic                  o_cmp_wr_en,
    output logic [7:0]            o_cmp_din,
    input  logic [CTX_W-1:0]      i_rd_ctx,
    input  logic [3:0]            i_addr,
    output logic [31:0]           o_dout,
    output logic [CTX_W-1:0]      o_active_ctx,
    output logic                  o_sign_extension_bug
);

    localparam logic [5:0]  SALT_LAST     = 6'(4 * SALT_WORDS - 1);
    localparam logic [3:0]  LAST_RD_ADDR  = 4'(SALT_WORDS);
    localparam logic [15:0] HNUM_MAX      = 16'(HASH_NUM_MAX);
    localparam logic [CTX_W-1:0] LAST_CTX = CTX_W'(NUM_CTX - 1);

    cfg_state_t r_state;
    cfg_state_t w_next_state;

    logic [5:0]            r_byte_cnt;
    logic [23:0]           r_acc;
    logic                  r_iter_ovf;
    logic                  r_shadow_bug;
    logic [HASH_CNT_W-1:0] r_hash_count;
    logic [CMP_AW-1:0]     r_cmp_wr_addr;
    logic [CMP_AW-1:0]     r_cmp_last;
    logic                  r_cmp_wr_en;
    logic [7:0]            r_cmp_din;
    logic [2:0]            r_err_code;
    logic [CTX_W-1:0]      r_active_ctx;
    logic                  r_sign_ext_bug;

    logic                  w_take;
    logic [31:0]           w_word;
    logic [15:0]           w_hcnt;
    logic [CMP_AW-1:0]     w_cmp_next_addr;
    logic [CTX_W-1:0]      w_shadow_ctx;
    logic                  w_set_err;
    logic [2:0]            w_err_val;
    logic                  w_ram_we;
    logic [3:0]            w_ram_addr;
    logic [31:0]           w_ram_rd;

    assign o_full           = (r_state == ST_WAIT) || (r_state == ST_ERROR);
    assign o_error          = (r_state == ST_ERROR);
    assign o_new_cmp_config = (r_state == ST_WAIT);
    assign w_take           = i_wr_en & ~o_full;
    assign w_word           = {i_din, r_acc};
    assign w_hcnt           = {i_din, r_hash_count[7:0]};
    assign w_cmp_next_addr  = r_cmp_wr_addr + CMP_AW'(1);
    assign w_shadow_ctx     = (r_active_ctx == LAST_CTX) ? '0 : r_active_ctx + CTX_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_SALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_set_err    = 1'b0;
        w_err_val    = ERR_NONE;
        w_ram_we     = 1'b0;
        w_ram_addr   = '0;
        case (r_state)
            ST_SALT: begin
                if (w_take) begin
                    if (r_byte_cnt[1:0] == 2'd3) begin
                        w_ram_we   = 1'b1;
                        w_ram_addr = r_byte_cnt[5:2] + 4'd1;
                    end
                    if (r_byte_cnt == SALT_LAST) begin
                        w_next_state = ST_SUBTYPE;
                    end
                end
            end
            ST_SUBTYPE: begin
                if (w_take) begin
                    if (is_valid_subtype(i_din)) begin
                        w_next_state = ST_ITER;
                    end else begin
                        w_set_err = 1'b1;
                        w_err_val = ERR_SUBTYPE;
                    end
                end
            end
            ST_ITER: begin
                if (w_take && (r_byte_cnt[1:0] == 2'd3)) begin
                    w_ram_we     = 1'b1;
                    w_ram_addr   = 4'd0;
                    w_next_state = ST_HCNT0;
                end
            end
            ST_HCNT0: begin
                if (w_take) begin
                    if (r_iter_ovf) begin
                        w_set_err = 1'b1;
                        w_err_val = ERR_ITER;
                    end else begin
                        w_next_state = ST_HCNT1;
                    end
                end
            end
            ST_HCNT1: begin
                if (w_take) begin
                    if (i_mode_cmp) begin
                        if (w_hcnt == 16'd0) begin
                            w_set_err = 1'b1;
                            w_err_val = ERR_HCNT_ZERO;
                        end else if (w_hcnt > HNUM_MAX) begin
                            w_set_err = 1'b1;
                            w_err_val = ERR_HCNT_RANGE;
                        end else begin
                            w_next_state = ST_CMP_DATA;
                        end
                    end else if (i_din != 8'd0) begin
                        w_set_err = 1'b1;
                        w_err_val = ERR_HCNT_NOCMP;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_CMP_DATA: begin
                if (w_take && (w_cmp_next_addr == r_cmp_last)) begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_cmp_config_applied) begin
                    w_next_state = ST_MAGIC;
                end
            end
            ST_MAGIC: begin
                if (w_take) begin
                    if (i_din == CFG_MAGIC) begin
                        w_next_state = ST_SALT;
                    end else begin
                        w_set_err = 1'b1;
                        w_err_val = ERR_MAGIC;
                    end
                end
            end
            ST_ERROR: begin
                if (i_err_clr) begin
                    w_next_state = ST_SALT;
                end
            end
            default: w_next_state = ST_SALT;
        endcase
        if (w_set_err) begin
            w_next_state = ST_ERROR;
        end
    end

    // Datapath: byte assembly, hash count, comparator write port and context commit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_byte_cnt     <= '0;
            r_acc          <= '0;
            r_iter_ovf     <= 1'b0;
            r_shadow_bug   <= 1'b0;
            r_hash_count   <= '0;
            r_cmp_wr_addr  <= '1;
            r_cmp_last     <= '0;
            r_cmp_wr_en    <= 1'b0;
            r_cmp_din      <= '0;
            r_err_code     <= ERR_NONE;
            r_active_ctx   <= '0;
            r_sign_ext_bug <= 1'b0;
        end else begin
            r_cmp_wr_en <= 1'b0;
            if (w_set_err) begin
                r_err_code <= w_err_val;
            end
            case (r_state)
                ST_SALT: begin
                    if (w_take) begin
                        r_acc      <= w_word[31:8];
                        r_byte_cnt <= (r_byte_cnt == SALT_LAST) ? 6'd0 : r_byte_cnt + 6'd1;
                    end
                end
                ST_SUBTYPE: begin
                    if (w_take) begin
                        r_shadow_bug <= (i_din == SUB_X);
                    end
                end
                ST_ITER: begin
                    if (w_take) begin
                        r_acc <= w_word[31:8];
                        if (r_byte_cnt[1:0] == 2'd3) begin
                            r_byte_cnt <= 6'd0;
                            r_iter_ovf <= |w_word[31:SETTING_MAX+1];
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 6'd1;
                        end
                    end
                end
                ST_HCNT0: begin
                    if (w_take) begin
                        r_hash_count <= HASH_CNT_W'(i_din);
                    end
                end
                ST_HCNT1: begin
                    if (w_take) begin
                        r_hash_count <= HASH_CNT_W'(w_hcnt);
                        if (w_next_state == ST_CMP_DATA) begin
                            r_cmp_wr_addr <= '1;
                            r_cmp_last    <= CMP_AW'({w_hcnt, 2'b00} - 18'd1);
                        end
                    end
                end
                ST_CMP_DATA: begin
                    if (w_take) begin
                        r_cmp_wr_en   <= 1'b1;
                        r_cmp_din     <= i_din;
                        r_cmp_wr_addr <= w_cmp_next_addr;
                    end
                end
                ST_WAIT: begin
                    if (i_cmp_config_applied) begin
                        r_active_ctx   <= w_shadow_ctx;
                        r_sign_ext_bug <= r_shadow_bug;
                    end
                end
                ST_ERROR: begin
                    if (i_err_clr) begin
                        r_err_code <= ERR_NONE;
                        r_byte_cnt <= 6'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    bcrypt_cfg_ctx_ram #(
        .NUM_CTX (NUM_CTX),
        .CTX_W   (CTX_W)
    ) u_ctx_ram (
        .i_clk     (i_clk),
        .i_we      (w_ram_we),
        .i_wr_ctx  (w_shadow_ctx),
        .i_wr_addr (w_ram_addr),
        .i_wr_data (w_word),
        .i_rd_ctx  (i_rd_ctx),
        .i_rd_addr (i_addr),
        .o_rd_data (w_ram_rd)
    );

    // Words past the last salt word are not part of a context and read as zero.
    assign o_dout               = (i_addr <= LAST_RD_ADDR) ? w_ram_rd : 32'd0;
    assign o_err_code           = r_err_code;
    assign o_hash_count         = r_hash_count;
    assign o_cmp_wr_addr        = r_cmp_wr_addr;
    assign o_cmp_wr_en          = r_cmp_wr_en;
    assign o_cmp_din            = r_cmp_din;
    assign o_active_ctx         = r_active_ctx;
    assign o_sign_extension_bug = r_sign_ext_bug;

endmodule
